// File: rtl/ram_rs_if.sv
// Dispatch, CDB, flush and FU-issue signals of the RAM reservation station.
// master drives dispatch/CDB/flush/fu_busy; slave is the station itself.
interface ram_rs_if;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_operand;
  logic [7:0]      in_flags;
  logic [7:0]      in_wbs;
  logic [3:0]      in_robid;
  logic [1:0]      in_dep_rdy;
  logic [1:0][7:0] in_dep_val;
  logic [1:0][3:0] in_dep_tag;

  logic            cdb_valid;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;

  logic            flush;
  logic            fu_busy;

  logic            out_transmit;
  logic [7:0]      out_operand;
  logic [7:0]      out_flags;
  logic [7:0]      out_wbs;
  logic [1:0][7:0] out_depvals;
  logic [3:0]      out_robid;

  modport master (
    output in_valid, in_operand, in_flags, in_wbs, in_robid,
           in_dep_rdy, in_dep_val, in_dep_tag,
           cdb_valid, cdb_id, cdb_val, flush, fu_busy,
    input  in_ready, out_transmit, out_operand, out_flags, out_wbs,
           out_depvals, out_robid
  );

  modport slave (
    input  in_valid, in_operand, in_flags, in_wbs, in_robid,
           in_dep_rdy, in_dep_val, in_dep_tag,
           cdb_valid, cdb_id, cdb_val, flush, fu_busy,
    output in_ready, out_transmit, out_operand, out_flags, out_wbs,
           out_depvals, out_robid
  );
endinterface

// File: rtl/ram_rs.sv
// In-order reservation station feeding the RAM FU; snoops the CDB for operands.
// Optional stall counter output enabled by defining RAM_RS_STALL_CNT_EN.
module ram_rs #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_rs_if.slave                  bus,
  output logic [$clog2(DEPTH):0]   count
`ifdef RAM_RS_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [7:0]       op_q    [DEPTH];
  logic [7:0]       op_d    [DEPTH];
  logic [7:0]       flags_q [DEPTH];
  logic [7:0]       flags_d [DEPTH];
  logic [7:0]       wbs_q   [DEPTH];
  logic [7:0]       wbs_d   [DEPTH];
  logic [3:0]       robid_q [DEPTH];
  logic [3:0]       robid_d [DEPTH];
  logic [1:0]       rdy_q   [DEPTH];
  logic [1:0]       rdy_d   [DEPTH];
  logic [1:0][7:0]  val_q   [DEPTH];
  logic [1:0][7:0]  val_d   [DEPTH];
  logic [1:0][3:0]  tag_q   [DEPTH];
  logic [1:0][3:0]  tag_d   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic            out_transmit_q, out_transmit_d;
  logic [7:0]      out_operand_q, out_operand_d;
  logic [7:0]      out_flags_q, out_flags_d;
  logic [7:0]      out_wbs_q, out_wbs_d;
  logic [1:0][7:0] out_depvals_q, out_depvals_d;
  logic [3:0]      out_robid_q, out_robid_d;

  logic in_ready;
  logic do_issue;
  logic do_alloc;

  // in_ready looks only at the registered count, so a same-cycle issue never frees a slot
  assign in_ready = (count_q != FULL_CNT);
  assign do_issue = !bus.flush && valid_q[head_q] && (&rdy_q[head_q]) && !bus.fu_busy;
  assign do_alloc = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    valid_d       = valid_q;
    op_d          = op_q;
    flags_d       = flags_q;
    wbs_d         = wbs_q;
    robid_d       = robid_q;
    rdy_d         = rdy_q;
    val_d         = val_q;
    tag_d         = tag_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    out_transmit_d = 1'b0;
    out_operand_d  = '0;
    out_flags_d    = '0;
    out_wbs_d      = '0;
    out_depvals_d  = '0;
    out_robid_d    = '0;

    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (valid_q[i] && !rdy_q[i][j] && bus.cdb_valid && (tag_q[i][j] == bus.cdb_id)) begin
          rdy_d[i][j] = 1'b1;
          val_d[i][j] = bus.cdb_val;
        end
      end
    end

    if (do_issue) begin
      valid_d[head_q] = 1'b0;
      out_transmit_d  = 1'b1;
      out_operand_d   = op_q[head_q];
      out_flags_d     = flags_q[head_q];
      out_wbs_d       = wbs_q[head_q];
      out_depvals_d   = val_q[head_q];
      out_robid_d     = robid_q[head_q];
      head_d          = head_q + 1'b1;
    end

    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = bus.in_operand;
      flags_d[tail_q] = bus.in_flags;
      wbs_d[tail_q]   = bus.in_wbs;
      robid_d[tail_q] = bus.in_robid;
      tag_d[tail_q]   = bus.in_dep_tag;
      for (int j = 0; j < 2; j++) begin
        if (!bus.in_dep_rdy[j] && bus.cdb_valid && (bus.in_dep_tag[j] == bus.cdb_id)) begin
          rdy_d[tail_q][j] = 1'b1;
          val_d[tail_q][j] = bus.cdb_val;
        end else begin
          rdy_d[tail_q][j] = bus.in_dep_rdy[j];
          val_d[tail_q][j] = bus.in_dep_val[j];
        end
      end
      tail_d = tail_q + 1'b1;
    end

    case ({do_alloc, do_issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      out_transmit_q <= 1'b0;
      out_operand_q  <= '0;
      out_flags_q    <= '0;
      out_wbs_q      <= '0;
      out_depvals_q  <= '0;
      out_robid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        flags_q[i] <= '0;
        wbs_q[i]   <= '0;
        robid_q[i] <= '0;
        rdy_q[i]   <= '0;
        val_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      out_transmit_q <= out_transmit_d;
      out_operand_q  <= out_operand_d;
      out_flags_q    <= out_flags_d;
      out_wbs_q      <= out_wbs_d;
      out_depvals_q  <= out_depvals_d;
      out_robid_q    <= out_robid_d;
      op_q           <= op_d;
      flags_q        <= flags_d;
      wbs_q          <= wbs_d;
      robid_q        <= robid_d;
      rdy_q          <= rdy_d;
      val_q          <= val_d;
      tag_q          <= tag_d;
    end
  end

`ifdef RAM_RS_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush deliberately leaves this untouched; it saturates rather than wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((count_q != '0) && !do_issue && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.out_transmit = out_transmit_q;
  assign bus.out_operand  = out_operand_q;
  assign bus.out_flags    = out_flags_q;
  assign bus.out_wbs      = out_wbs_q;
  assign bus.out_depvals  = out_depvals_q;
  assign bus.out_robid    = out_robid_q;
  assign count            = count_q;

endmodule

// File: tb/tb_ram_rs.sv
// Table-driven bench for ram_rs (DEPTH=4): one vector per clock, outputs checked
// at the following negedge; wbs is derived from robid as {4'hB, robid}.
module tb_ram_rs;
  logic       clk;
  logic       rst;
  logic [2:0] count;
`ifdef RAM_RS_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          stall_exp;
  logic [2:0]  pre_count;
`endif

  ram_rs_if bus();

  ram_rs #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
`ifdef RAM_RS_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [7:0] op;
    logic [7:0] fl;
    logic [3:0] rid;
    logic [1:0] rdy;
    logic [7:0] v1;
    logic [7:0] v0;
    logic [3:0] t1;
    logic [3:0] t0;
    logic       cv;
    logic [3:0] cid;
    logic [7:0] cval;
    logic       fls;
    logic       busy;
    logic       etx;
    logic [7:0] eop;
    logic [7:0] efl;
    logic [3:0] erid;
    logic [7:0] ev1;
    logic [7:0] ev0;
    logic [2:0] ecnt;
    logic       erdy;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mkv(
    input logic iv, input logic [7:0] op, input logic [7:0] fl, input logic [3:0] rid,
    input logic [1:0] rdy, input logic [7:0] v1, input logic [7:0] v0,
    input logic [3:0] t1, input logic [3:0] t0,
    input logic cv, input logic [3:0] cid, input logic [7:0] cval,
    input logic fls, input logic busy,
    input logic etx, input logic [7:0] eop, input logic [7:0] efl, input logic [3:0] erid,
    input logic [7:0] ev1, input logic [7:0] ev0, input logic [2:0] ecnt, input logic erdy);
    vec_t r;
    r.iv = iv;   r.op = op;   r.fl = fl;   r.rid = rid;  r.rdy = rdy;
    r.v1 = v1;   r.v0 = v0;   r.t1 = t1;   r.t0 = t0;
    r.cv = cv;   r.cid = cid; r.cval = cval;
    r.fls = fls; r.busy = busy;
    r.etx = etx; r.eop = eop; r.efl = efl; r.erid = erid;
    r.ev1 = ev1; r.ev0 = ev0; r.ecnt = ecnt; r.erdy = erdy;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t s);
    bus.in_valid   = s.iv;
    bus.in_operand = s.op;
    bus.in_flags   = s.fl;
    bus.in_wbs     = {4'hB, s.rid};
    bus.in_robid   = s.rid;
    bus.in_dep_rdy = s.rdy;
    bus.in_dep_val = {s.v1, s.v0};
    bus.in_dep_tag = {s.t1, s.t0};
    bus.cdb_valid  = s.cv;
    bus.cdb_id     = s.cid;
    bus.cdb_val    = s.cval;
    bus.flush      = s.fls;
    bus.fu_busy    = s.busy;
  endtask

  task automatic check_output(input vec_t e, input int idx);
    check("transmit", idx, 32'(bus.out_transmit), 32'(e.etx));
    check("operand",  idx, 32'(bus.out_operand),  32'(e.eop));
    check("flags",    idx, 32'(bus.out_flags),    32'(e.efl));
    check("wbs",      idx, 32'(bus.out_wbs),      e.etx ? 32'({4'hB, e.erid}) : 32'h0);
    check("robid",    idx, 32'(bus.out_robid),    32'(e.erid));
    check("depvals",  idx, 32'({bus.out_depvals[1], bus.out_depvals[0]}), 32'({e.ev1, e.ev0}));
    check("count",    idx, 32'(count),            32'(e.ecnt));
    check("in_ready", idx, 32'(bus.in_ready),     32'(e.erdy));
`ifdef RAM_RS_STALL_CNT_EN
    if ((pre_count != 3'd0) && !e.etx) stall_exp++;
    pre_count = e.ecnt;
    check("stall_cnt", idx, 32'(stall_cnt), 32'(stall_exp));
`endif
  endtask

  task automatic run_vec(input vec_t s, input int idx);
    apply_stimulus(s);
    @(posedge clk);
    @(negedge clk);
    check_output(s, idx);
  endtask

  initial begin
    // Single-cycle store, CDB wait with in-order pair, fill/drain under fu_busy
    vq.push_back(mkv(1,'h11,'h02,3,2'b11,'h10,'hA5,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h11,'h02,3,'h10,'hA5, 0,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));
    vq.push_back(mkv(1,'h21,0,4,2'b01,0,0,5,0, 0,0,0, 0,0, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(1,'h22,0,6,2'b11,'h30,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 2,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 1,5,'h20, 0,0, 0,0,0,0,0,0, 2,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h21,0,4,'h20,0, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h22,0,6,'h30,0, 0,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));
    vq.push_back(mkv(1,'h40,0,8,2'b11,'h50,'h60,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(1,'h41,0,9,2'b11,'h51,'h61,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 2,1));
    vq.push_back(mkv(1,'h42,0,'hA,2'b11,'h52,'h62,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 3,1));
    vq.push_back(mkv(1,'h43,0,'hB,2'b11,'h53,'h63,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 4,0));
    vq.push_back(mkv(1,'h44,0,'hC,2'b11,'h54,'h64,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 4,0));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h40,0,8,'h50,'h60, 3,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h41,0,9,'h51,'h61, 2,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h42,0,'hA,'h52,'h62, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h43,0,'hB,'h53,'h63, 0,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));
    // Same-cycle CDB capture on allocate, non-matching broadcast, dual-operand capture
    vq.push_back(mkv(1,'h70,'h02,1,2'b10,'h33,0,0,7, 1,7,'h77, 0,0, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h70,'h02,1,'h33,'h77, 0,1));
    vq.push_back(mkv(1,'h71,0,2,2'b00,0,0,9,9, 1,8,'hEE, 0,0, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 1,9,'h99, 0,0, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 1,'h71,0,2,'h99,'h99, 0,1));
    // Flush with three resident entries and an offered beat
    vq.push_back(mkv(1,'h90,'h02,3,2'b11,'h01,'h02,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 1,1));
    vq.push_back(mkv(1,'h91,'h02,4,2'b11,'h01,'h02,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 2,1));
    vq.push_back(mkv(1,'h92,'h02,5,2'b11,'h01,'h02,0,0, 0,0,0, 0,1, 0,0,0,0,0,0, 3,1));
    vq.push_back(mkv(1,'h93,'h02,6,2'b11,'h01,'h02,0,0, 0,0,0, 1,0, 0,0,0,0,0,0, 0,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));
    vq.push_back(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));

    rst = 1'b0;
    apply_stimulus(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1));
`ifdef RAM_RS_STALL_CNT_EN
    stall_exp = 0;
    pre_count = 3'd0;
`endif
    repeat (2) @(negedge clk);
    check_output(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1), -1);
    rst = 1'b1;

    foreach (vq[i]) run_vec(vq[i], i);

    // Continuous allocate+issue of 10 ops across two pointer wraps
    for (int k = 0; k <= 10; k++) begin
      logic [7:0] kb;
      logic [7:0] pb;
      kb = 8'(k);
      pb = 8'(k - 1);
      v = mkv(k < 10, 8'h80 | kb, {6'b0, kb[0], 1'b0}, kb[3:0], 2'b11, kb, 8'hF0 | kb, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k < 10) ? 3'd1 : 3'd0, 1);
      if (k > 0) begin
        v.etx  = 1'b1;
        v.eop  = 8'h80 | pb;
        v.efl  = {6'b0, pb[0], 1'b0};
        v.erid = pb[3:0];
        v.ev1  = pb;
        v.ev0  = 8'hF0 | pb;
      end
      run_vec(v, 100 + k);
    end
    run_vec(mkv(0,0,0,0,2'b00,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,1), 111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
